fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/inst_fifo.sv | 66 ++++++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the reset fetch address and the
// fetch-buffer entry layout used by the fetch stage and its instruction FIFO.
package cpu_pkg;

   localparam int PC_W   = 32;
   localparam int INST_W = 32;

   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h1bc00000;

   // One fetched instruction together with the PC it was fetched from
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Sequential successor of a fetch address, wrapping at the top of memory
   function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
      return pc + PC_W'(4);
   endfunction

   // Word-aligned version of an address (low two bits cleared)
   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
      return pc & ~PC_W'(3);
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries between the
// instruction SRAM response and decode. Flush empties it in one cycle and
// takes priority over a simultaneous write or read. The head entry is read
// straight out of the storage registers.
module inst_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   flush,
   input  logic                   wr_en,
   input  fetch_entry_t           wr_data,
   input  logic                   rd_en,
   output fetch_entry_t           rd_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Entry storage: capture the incoming response unless the buffer is being flushed
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; a write and a read together leave the count unchanged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the fetch PC, issues one SRAM read per cycle
// while the buffer has room, and queues responses for decode. A branch
// redirect flushes everything and restarts fetching at the target.
// Optional macro FETCH_ADEF_CHECK_EN: misaligned redirect targets are fetched
// (address forced aligned), flagged with fs_adef, and fetching stalls until
// the next redirect. Without it the target is simply word-aligned.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH = 2
)
(
   input  logic              clk,
   input  logic              resetn,
   output logic              inst_sram_en,
   output logic              inst_sram_wen,
   output logic [PC_W-1:0]   inst_sram_addr,
   output logic [INST_W-1:0] inst_sram_wdata,
   input  logic [INST_W-1:0] inst_sram_rdata,
   output logic              fs_valid,
   output logic [PC_W-1:0]   fs_pc,
   output logic [INST_W-1:0] fs_inst,
   input  logic              ds_allow_in,
   input  logic              br_taken,
   input  logic [PC_W-1:0]   br_target,
   output logic              fs_adef
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] req_pc;
   logic [PC_W-1:0] load_pc;
   logic            in_flight;
   logic            pop;
   logic            issue;
   logic            resp_wr;
   logic            fetch_block;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    resp_entry;
   fetch_entry_t    head;

   assign pop = fs_valid & ds_allow_in;

   // Room check counts the buffered entries plus the response still on its way,
   // minus the entry decode takes this cycle, so back-to-back fetch is sustained
   assign issue = ~br_taken & ~fetch_block &
                  ((int'(fifo_count) + int'(in_flight) - int'(pop)) < FIFO_DEPTH);

   assign resp_wr    = in_flight & ~br_taken;
   assign resp_entry = '{pc: req_pc, inst: inst_sram_rdata};

   inst_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_inst_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .flush   (br_taken),
      .wr_en   (resp_wr),
      .wr_data (resp_entry),
      .rd_en   (pop),
      .rd_data (head),
      .count   (fifo_count)
   );

`ifdef FETCH_ADEF_CHECK_EN
   logic adef_stall;

   assign load_pc     = br_target;
   assign fetch_block = adef_stall;
   assign fs_adef     = fs_valid & (head.pc[1:0] != 2'b00);

   // Once a misaligned address has been requested, hold fetching until the next redirect
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         adef_stall <= 1'b0;
      end else if (br_taken) begin
         adef_stall <= 1'b0;
      end else if (issue && (pc[1:0] != 2'b00)) begin
         adef_stall <= 1'b1;
      end
   end
`else
   assign load_pc     = word_align(br_target);
   assign fetch_block = 1'b0;
   assign fs_adef     = 1'b0;
`endif

   // Fetch PC and in-flight tracking; a redirect always wins over sequential advance
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc        <= RESET_PC;
         req_pc    <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= issue;
         if (br_taken) begin
            pc <= load_pc;
         end else if (issue) begin
            pc     <= next_pc(pc);
            req_pc <= pc;
         end
      end
   end

   assign inst_sram_en    = resetn & issue;
   assign inst_sram_wen   = 1'b0;
   assign inst_sram_addr  = word_align(pc);
   assign inst_sram_wdata = '0;

   assign fs_valid = (fifo_count != '0);
   assign fs_pc    = head.pc;
   assign fs_inst  = head.inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage (default FIFO_DEPTH of 2). A directed
// cycle table covers start-up, stall/release and redirects; hand sequences
// cover the misaligned-target behaviour and a mid-stream reset; a randomized
// run is checked against an in-order stream model of the fetch stage.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h1bc00000;
   localparam int          DEPTH    = 2;

`ifdef FETCH_ADEF_CHECK_EN
   localparam logic [31:0] ADEF_PC  = 32'h1c000102;
   localparam logic        ADEF_BIT = 1'b1;
   localparam logic        AFTER_EN = 1'b0;
`else
   localparam logic [31:0] ADEF_PC  = 32'h1c000100;
   localparam logic        ADEF_BIT = 1'b0;
   localparam logic        AFTER_EN = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_sram_en;
   logic        inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata = '0;
   logic        fs_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        ds_allow_in = 1'b1;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic        fs_adef;

   int   check_count = 0;
   int   error_count = 0;
   logic scramble = 1'b0;

   typedef struct {
      logic        ds;
      logic        br;
      logic [31:0] target;
      logic        exp_en;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vector_t;

   vector_t vec [21];

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_wen   (inst_sram_wen),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .fs_valid        (fs_valid),
      .fs_pc           (fs_pc),
      .fs_inst         (fs_inst),
      .ds_allow_in     (ds_allow_in),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .fs_adef         (fs_adef)
   );

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return scramble ? (a ^ 32'h3c5a96e1) : a;
   endfunction

   function automatic logic [31:0] seq_pc(input int n);
      return RESET_PC + 32'(4 * n);
   endfunction

   // Instruction SRAM: answers an accepted request on the next cycle, garbage otherwise
   always @(posedge clk) begin
      if (inst_sram_en) inst_sram_rdata <= data_of(inst_sram_addr);
      else              inst_sram_rdata <= $urandom();
   end

   task automatic applyStimulus(input logic ds, input logic br, input logic [31:0] tgt);
      ds_allow_in = ds;
      br_taken    = br;
      br_target   = tgt;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] tgt_t;
      logic [31:0] tgt_u;
      logic        ds;
      logic        br;
      logic        pop;
      logic [31:0] tgt;
      logic [31:0] exp_fetch;
      logic [31:0] exp_deliver;
      int          outstanding;
      int          n;

      tgt_t = 32'h1c000100;
      tgt_u = 32'h1c000200;

      // cycle 0 is the first cycle with resetn high
      vec[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, seq_pc(0), 1'b0, 32'h0};
      vec[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, seq_pc(1), 1'b0, 32'h0};
      vec[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, seq_pc(2), 1'b1, seq_pc(0)};
      vec[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, seq_pc(3), 1'b1, seq_pc(1)};
      vec[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, seq_pc(4), 1'b1, seq_pc(2)};
      vec[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, seq_pc(5), 1'b1, seq_pc(3)};
      vec[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, seq_pc(5), 1'b1, seq_pc(3)};
      vec[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, seq_pc(5), 1'b1, seq_pc(3)};
      vec[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, seq_pc(5), 1'b1, seq_pc(3)};
      vec[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, seq_pc(5), 1'b1, seq_pc(3)};
      vec[10] = '{1'b1, 1'b0, 32'h0,  1'b1, seq_pc(5), 1'b1, seq_pc(3)};
      vec[11] = '{1'b1, 1'b0, 32'h0,  1'b1, seq_pc(6), 1'b1, seq_pc(4)};
      vec[12] = '{1'b1, 1'b0, 32'h0,  1'b1, seq_pc(7), 1'b1, seq_pc(5)};
      vec[13] = '{1'b0, 1'b1, tgt_t,  1'b0, seq_pc(8), 1'b1, seq_pc(6)};
      vec[14] = '{1'b1, 1'b0, 32'h0,  1'b1, tgt_t,      1'b0, 32'h0};
      vec[15] = '{1'b1, 1'b0, 32'h0,  1'b1, tgt_t + 4,  1'b0, 32'h0};
      vec[16] = '{1'b1, 1'b0, 32'h0,  1'b1, tgt_t + 8,  1'b1, tgt_t};
      vec[17] = '{1'b1, 1'b1, tgt_u,  1'b0, tgt_t + 12, 1'b1, tgt_t + 4};
      vec[18] = '{1'b1, 1'b0, 32'h0,  1'b1, tgt_u,      1'b0, 32'h0};
      vec[19] = '{1'b1, 1'b0, 32'h0,  1'b1, tgt_u + 4,  1'b0, 32'h0};
      vec[20] = '{1'b1, 1'b0, 32'h0,  1'b1, tgt_u + 8,  1'b1, tgt_u};

      $display("[TB] reset state");
      applyStimulus(1'b1, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_en",    inst_sram_en,    32'h0);
      checkOutput("rst_addr",  inst_sram_addr,  RESET_PC);
      checkOutput("rst_valid", fs_valid,        32'h0);
      checkOutput("rst_pc",    fs_pc,           32'h0);
      checkOutput("rst_inst",  fs_inst,         32'h0);
      checkOutput("rst_adef",  fs_adef,         32'h0);
      checkOutput("rst_wen",   inst_sram_wen,   32'h0);
      checkOutput("rst_wdata", inst_sram_wdata, 32'h0);

      $display("[TB] directed table");
      resetn = 1'b1;
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vec[i].ds, vec[i].br, vec[i].target);
         #4;
         checkOutput($sformatf("tbl_en[%0d]", i),    inst_sram_en,   vec[i].exp_en);
         checkOutput($sformatf("tbl_addr[%0d]", i),  inst_sram_addr, vec[i].exp_addr);
         checkOutput($sformatf("tbl_valid[%0d]", i), fs_valid,       vec[i].exp_valid);
         if (vec[i].exp_valid) begin
            checkOutput($sformatf("tbl_pc[%0d]", i),   fs_pc,   vec[i].exp_pc);
            checkOutput($sformatf("tbl_inst[%0d]", i), fs_inst, vec[i].exp_pc);
         end
         checkOutput($sformatf("tbl_adef[%0d]", i), fs_adef, 32'h0);
         nextCycle();
      end

      $display("[TB] misaligned redirect target");
      applyStimulus(1'b1, 1'b1, 32'h1c000102);
      #4 checkOutput("adef_redirect_en", inst_sram_en, 32'h0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      #4 checkOutput("adef_req_en", inst_sram_en, 32'h1);
      checkOutput("adef_req_addr", inst_sram_addr, 32'h1c000100);
      nextCycle();
      #4 checkOutput("adef_en_c1", inst_sram_en, AFTER_EN);
      nextCycle();
      #4 checkOutput("adef_valid", fs_valid, 32'h1);
      checkOutput("adef_pc",    fs_pc,        ADEF_PC);
      checkOutput("adef_inst",  fs_inst,      32'h1c000100);
      checkOutput("adef_flag",  fs_adef,      ADEF_BIT);
      checkOutput("adef_en_c2", inst_sram_en, AFTER_EN);
      nextCycle();
      #4 checkOutput("adef_en_c3", inst_sram_en, AFTER_EN);
      checkOutput("adef_valid_after", fs_valid, AFTER_EN);
      nextCycle();

      $display("[TB] mid-stream reset");
      applyStimulus(1'b1, 1'b1, 32'h1bd00000);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      repeat (5) nextCycle();
      #1 resetn = 1'b0;
      scramble = 1'b1;
      #1;
      checkOutput("async_en",    inst_sram_en,   32'h0);
      checkOutput("async_addr",  inst_sram_addr, RESET_PC);
      checkOutput("async_valid", fs_valid,       32'h0);
      checkOutput("async_pc",    fs_pc,          32'h0);
      checkOutput("async_inst",  fs_inst,        32'h0);
      checkOutput("async_adef",  fs_adef,        32'h0);
      @(posedge clk);
      #1 resetn = 1'b1;

      $display("[TB] randomized run against stream model");
      exp_fetch   = RESET_PC;
      exp_deliver = RESET_PC;
      outstanding = 0;
      n           = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         ds  = ($urandom_range(3) != 0);
         br  = ($urandom_range(15) == 0);
         tgt = $urandom() & 32'hfffffffc;
         applyStimulus(ds, br, tgt);
         #4;
         pop = fs_valid & ds;
         if (br) checkOutput($sformatf("rnd_en_redirect@%0d", cyc), inst_sram_en, 32'h0);
         else if (n == 0) checkOutput($sformatf("rnd_en_restart@%0d", cyc), inst_sram_en, 32'h1);
         if (inst_sram_en) begin
            checkOutput($sformatf("rnd_addr@%0d", cyc), inst_sram_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            outstanding++;
         end
         checkOutput($sformatf("rnd_valid@%0d", cyc), fs_valid, (n >= 2) ? 32'h1 : 32'h0);
         if (fs_valid) begin
            checkOutput($sformatf("rnd_pc@%0d", cyc),   fs_pc,   exp_deliver);
            checkOutput($sformatf("rnd_inst@%0d", cyc), fs_inst, data_of(exp_deliver));
         end
         checkOutput($sformatf("rnd_adef@%0d", cyc),  fs_adef,         32'h0);
         checkOutput($sformatf("rnd_wen@%0d", cyc),   inst_sram_wen,   32'h0);
         checkOutput($sformatf("rnd_wdata@%0d", cyc), inst_sram_wdata, 32'h0);
         if (pop) begin
            exp_deliver = exp_deliver + 32'd4;
            outstanding--;
         end
         checkOutput($sformatf("rnd_room@%0d", cyc), (outstanding <= DEPTH) ? 32'h1 : 32'h0, 32'h1);
         if (br) begin
            exp_fetch   = tgt;
            exp_deliver = tgt;
            outstanding = 0;
            n           = 0;
         end else begin
            n++;
         end
         nextCycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
